// File: rtl/snoop_split_if.sv
// rtl/snoop_split_if.sv - packet-memory write port bundle (addr/data/strobe/done plus ready back-pressure)
interface snoop_split_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  done;
  logic                  mem_ready;

  // The writer drives address/data/strobes; the memory side answers with ready.
  modport master (output wr_addr, wr_data, wr_en, done, input mem_ready);
  modport slave  (input  wr_addr, wr_data, wr_en, done, output mem_ready);
endinterface

// File: rtl/snoop_split.sv
// rtl/snoop_split.sv - 1-to-2 packet demux with round-robin branch choice; optional SNOOP_SPLIT_WR_GATE_EN gates writes with ready
module snoop_split #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10
) (
  input  logic          clk,
  input  logic          rst,
  snoop_split_if.slave  up_i,
  snoop_split_if.master left_o,
  snoop_split_if.master right_o,
  output logic          choice_o
);

  // IDLE: between packets; BUSY: packet in flight; HOLD: one cycle after done.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   choice_q, choice_d;

  logic                  sel_ready;
  logic                  oth_ready;
  logic                  wr_en_g;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0] data_w;

  // Ready of the branch currently selected and of the other one.
  assign sel_ready = choice_q ? right_o.mem_ready : left_o.mem_ready;
  assign oth_ready = choice_q ? left_o.mem_ready  : right_o.mem_ready;

  assign up_i.mem_ready = sel_ready;
  assign choice_o       = choice_q;

`ifdef SNOOP_SPLIT_WR_GATE_EN
  // Writes issued while the selected side is stalled are dropped.
  assign wr_en_g = up_i.wr_en & sel_ready;
`else
  assign wr_en_g = up_i.wr_en;
`endif

  // Address and data are broadcast; only the strobes are steered.
  assign addr_w = up_i.wr_addr;
  assign data_w = up_i.wr_data;

  assign left_o.wr_addr  = addr_w;
  assign left_o.wr_data  = data_w;
  assign right_o.wr_addr = addr_w;
  assign right_o.wr_data = data_w;

  assign left_o.wr_en  = wr_en_g & ~choice_q;
  assign right_o.wr_en = wr_en_g &  choice_q;
  assign left_o.done   = up_i.done & ~choice_q;
  assign right_o.done  = up_i.done &  choice_q;

  // Packet state and branch choice registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      choice_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      choice_q <= choice_d;
    end
  end

  // Next state: done flips the branch; fallback only when fully idle and no write arrives.
  always_comb begin
    state_d  = state_q;
    choice_d = choice_q;
    if (up_i.done) begin
      state_d  = ST_HOLD;
      choice_d = ~choice_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (up_i.wr_en) begin
            state_d = ST_BUSY;
          end else if (!sel_ready && oth_ready) begin
            choice_d = ~choice_q;
          end
        end
        ST_BUSY: state_d = ST_BUSY;
        ST_HOLD: state_d = up_i.wr_en ? ST_BUSY : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_split.sv
// tb/tb_snoop_split.sv - randomized and directed bench for snoop_split against a behavioural model
module tb_snoop_split;

  localparam int DW = 64;
  localparam int AW = 10;

  logic clk;
  logic rst;
  logic t_rst;
  logic m_choice_o;
  logic t_root_choice, t_lleaf_choice, t_rleaf_choice;

  int n_cmp;
  int n_bad;

  snoop_split_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m_up ();
  snoop_split_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m_l ();
  snoop_split_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m_r ();

  snoop_split #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .up_i     (m_up),
    .left_o   (m_l),
    .right_o  (m_r),
    .choice_o (m_choice_o)
  );

  // Two-level tree: root -> two leaves -> memories A,B (left leaf) and C,D (right leaf).
  snoop_split_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) t_up ();
  snoop_split_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) t_l ();
  snoop_split_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) t_r ();
  snoop_split_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) t_a ();
  snoop_split_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) t_b ();
  snoop_split_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) t_c ();
  snoop_split_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) t_d ();

  snoop_split #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_root (
    .clk(clk), .rst(t_rst), .up_i(t_up), .left_o(t_l), .right_o(t_r), .choice_o(t_root_choice)
  );
  snoop_split #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_lleaf (
    .clk(clk), .rst(t_rst), .up_i(t_l), .left_o(t_a), .right_o(t_b), .choice_o(t_lleaf_choice)
  );
  snoop_split #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_rleaf (
    .clk(clk), .rst(t_rst), .up_i(t_r), .left_o(t_c), .right_o(t_d), .choice_o(t_rleaf_choice)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: which branch is selected, whether a packet is open, post-done holdoff.
  bit mdl_choice, mdl_open, mdl_holdoff;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_choice  = 1'b0;
      mdl_open    = 1'b0;
      mdl_holdoff = 1'b0;
    end else if (m_up.done) begin
      mdl_choice  = !mdl_choice;
      mdl_open    = 1'b0;
      mdl_holdoff = 1'b1;
    end else begin
      if (!mdl_open && !mdl_holdoff && !m_up.wr_en) begin
        if (mdl_choice == 1'b0 && !m_l.mem_ready && m_r.mem_ready) mdl_choice = 1'b1;
        else if (mdl_choice == 1'b1 && !m_r.mem_ready && m_l.mem_ready) mdl_choice = 1'b0;
      end
      if (m_up.wr_en) mdl_open = 1'b1;
      mdl_holdoff = 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Full output check against the model for the current inputs.
  task automatic compare_all();
    logic exp_ready, exp_we;
    exp_ready = mdl_choice ? m_r.mem_ready : m_l.mem_ready;
`ifdef SNOOP_SPLIT_WR_GATE_EN
    exp_we = m_up.wr_en & exp_ready;
`else
    exp_we = m_up.wr_en;
`endif
    check("choice",      {63'd0, m_choice_o},  {63'd0, mdl_choice});
    check("mem_ready",   {63'd0, m_up.mem_ready}, {63'd0, exp_ready});
    check("wr_en_left",  {63'd0, m_l.wr_en},   {63'd0, exp_we && !mdl_choice});
    check("wr_en_right", {63'd0, m_r.wr_en},   {63'd0, exp_we && mdl_choice});
    check("done_left",   {63'd0, m_l.done},    {63'd0, m_up.done && !mdl_choice});
    check("done_right",  {63'd0, m_r.done},    {63'd0, m_up.done && mdl_choice});
    check("addr_left",   {54'd0, m_l.wr_addr}, {54'd0, m_up.wr_addr});
    check("addr_right",  {54'd0, m_r.wr_addr}, {54'd0, m_up.wr_addr});
    check("data_left",   m_l.wr_data, m_up.wr_data);
    check("data_right",  m_r.wr_data, m_up.wr_data);
  endtask

  // One clock: compare at the falling edge, then step past the next rising edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic tree_step();
    @(posedge clk);
    #1;
  endtask

  function automatic int leaf_hit();
    int idx;
    idx = -1;
    if (t_a.wr_en) idx = 0;
    if (t_b.wr_en) idx = (idx < 0) ? 1 : 9;
    if (t_c.wr_en) idx = (idx < 0) ? 2 : 9;
    if (t_d.wr_en) idx = (idx < 0) ? 3 : 9;
    return idx;
  endfunction

  int exp_leaf [5] = '{0, 2, 1, 3, 0};

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    t_rst = 1'b1;
    m_up.wr_addr = '0; m_up.wr_data = '0; m_up.wr_en = 1'b0; m_up.done = 1'b0;
    m_l.mem_ready = 1'b1; m_r.mem_ready = 1'b1;
    t_up.wr_addr = '0; t_up.wr_data = '0; t_up.wr_en = 1'b0; t_up.done = 1'b0;
    t_a.mem_ready = 1'b1; t_b.mem_ready = 1'b1; t_c.mem_ready = 1'b1; t_d.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    t_rst = 1'b0;

    // Reset state, then first write goes left and address is broadcast.
    #1;
    check("lit_rst_choice", {63'd0, m_choice_o}, 64'd0);
    check("lit_rst_ready",  {63'd0, m_up.mem_ready}, 64'd1);
    tick();
    m_up.wr_en = 1'b1; m_up.wr_addr = 10'd5; m_up.wr_data = 64'hDEAD_BEEF_0123_4567;
    #1;
    check("lit_wr_en_left",  {63'd0, m_l.wr_en}, 64'd1);
    check("lit_wr_en_right", {63'd0, m_r.wr_en}, 64'd0);
    check("lit_addr_right",  {54'd0, m_r.wr_addr}, 64'd5);
    tick();

    // done on left packet, then right selected with right not ready.
    m_up.wr_en = 1'b0; m_up.done = 1'b1;
    #1;
    check("lit_done_left",  {63'd0, m_l.done}, 64'd1);
    check("lit_done_right", {63'd0, m_r.done}, 64'd0);
    tick();
    m_up.done = 1'b0; m_r.mem_ready = 1'b0; m_l.mem_ready = 1'b1;
    #1;
    check("lit_after_done_choice", {63'd0, m_choice_o}, 64'd1);
    check("lit_follow_right_ready", {63'd0, m_up.mem_ready}, 64'd0);
    tick();
    #1;
    check("lit_holdoff_no_switch", {63'd0, m_choice_o}, 64'd1);
    tick();
    #1;
    check("lit_fallback_choice", {63'd0, m_choice_o}, 64'd0);
    check("lit_fallback_ready",  {63'd0, m_up.mem_ready}, 64'd1);
    tick();

    // Left finishes, its ready drops one cycle late: must not bounce back.
    m_r.mem_ready = 1'b1; m_up.wr_en = 1'b1;
    tick();
    m_up.wr_en = 1'b0; m_up.done = 1'b1;
    tick();
    m_up.done = 1'b0; m_l.mem_ready = 1'b0;
    #1;
    check("lit_no_bounce_0", {63'd0, m_choice_o}, 64'd1);
    tick();
    #1;
    check("lit_no_bounce_1", {63'd0, m_choice_o}, 64'd1);
    tick();

    // Stall with both sides not ready, then left recovers.
    m_l.mem_ready = 1'b1; m_r.mem_ready = 1'b0;
    tick();
    m_l.mem_ready = 1'b0;
    #1;
    check("lit_stall_ready", {63'd0, m_up.mem_ready}, 64'd0);
    repeat (3) tick();
    check("lit_stall_choice", {63'd0, m_choice_o}, 64'd0);
    m_l.mem_ready = 1'b1;
    #1;
    check("lit_recover_ready", {63'd0, m_up.mem_ready}, 64'd1);
    tick();

    // Reset mid-packet on the right branch.
    m_r.mem_ready = 1'b1; m_up.wr_en = 1'b1;
    tick();
    m_up.wr_en = 1'b0; m_up.done = 1'b1;
    tick();
    m_up.done = 1'b0; m_up.wr_en = 1'b1;
    tick();
    m_up.wr_en = 1'b0;
    check("lit_pre_rst_choice", {63'd0, m_choice_o}, 64'd1);
    rst = 1'b1;
    #1;
    check("lit_rst_mid_choice", {63'd0, m_choice_o}, 64'd0);
    rst = 1'b0;
    tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      m_up.wr_en   = ($urandom_range(0, 9) < 4);
      m_up.done    = ($urandom_range(0, 9) == 0);
      m_up.wr_addr = AW'($urandom);
      m_up.wr_data = {$urandom, $urandom};
      m_l.mem_ready = ($urandom_range(0, 3) != 0);
      m_r.mem_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    m_up.wr_en = 1'b0; m_up.done = 1'b0;

    // Tree: five single-beat packets land on A,C,B,D,A.
    for (int p = 0; p < 5; p++) begin
      t_up.wr_en = 1'b1; t_up.wr_addr = AW'(p);
      #1;
      check($sformatf("tree_pkt%0d_leaf", p), 64'(leaf_hit()), 64'(exp_leaf[p]));
      tree_step();
      t_up.wr_en = 1'b0; t_up.done = 1'b1;
      tree_step();
      t_up.done = 1'b0;
      tree_step();
    end
    t_up.wr_en = 1'b1;
    tree_step();
    t_up.wr_en = 1'b0;
    check("tree_pre_rst_root", {63'd0, t_root_choice}, 64'd1);
    t_rst = 1'b1;
    #1;
    check("tree_rst_root",  {63'd0, t_root_choice}, 64'd0);
    check("tree_rst_lleaf", {63'd0, t_lleaf_choice}, 64'd0);
    check("tree_rst_rleaf", {63'd0, t_rleaf_choice}, 64'd0);
    t_rst = 1'b0;
    tree_step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
